// File: rtl/obi_edge_irq_ctrl_if.sv
// OBI subordinate bus bundle for obi_edge_irq_ctrl.
// The master modport drives requests; the slave modport answers them.
interface obi_edge_irq_ctrl_if;
  logic        req;
  logic        gnt;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        aid;
  logic        rvalid;
  logic [31:0] rdata;
  logic        rid;
  logic        err;

  modport master (output req, addr, we, be, wdata, aid,
                  input  gnt, rvalid, rdata, rid, err);
  modport slave  (input  req, addr, we, be, wdata, aid,
                  output gnt, rvalid, rdata, rid, err);
endinterface

// File: rtl/obi_edge_irq_ctrl.sv
// Multi-channel edge-detect interrupt controller with an OBI register port.
// Optional input debouncing is compiled in with EDGE_IRQ_DEBOUNCE_EN.
module obi_edge_irq_ctrl #(
  parameter int unsigned NumChannels    = 16,
  parameter int unsigned CntWidth       = 16,
  parameter int unsigned DebounceCycles = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  obi_edge_irq_ctrl_if.slave     bus,
  input  logic [NumChannels-1:0] gpio_i,
  output logic                   irq_o
);
  localparam int unsigned MW = 2 * NumChannels;

  logic                   en_q, en_d;
  logic [MW-1:0]          mode_q, mode_d;
  logic [NumChannels-1:0] irq_en_q, irq_en_d;
  logic [NumChannels-1:0] pending_q, pending_d;
  logic [NumChannels-1:0] prev_q, prev_d;
  logic [CntWidth-1:0]    cnt_q, cnt_d;
  logic                   rvalid_q, rvalid_d;
  logic [31:0]            rdata_q, rdata_d;
  logic                   rid_q, rid_d;
  logic                   err_q, err_d;

  logic [NumChannels-1:0] filt;
  logic [NumChannels-1:0] edge_det;
  logic [NumChannels-1:0] w1c;
  logic [31:0]            wmask;
  logic [31:0]            rd_val;
  logic [5:0]             idx;
  logic                   idx_ok;
  logic                   wr_ok;
  logic                   cnt_clr;
  logic                   unused_bus;

  assign idx        = bus.addr[7:2];
  assign idx_ok     = (idx <= 6'd5);
  assign wr_ok      = bus.req & bus.we & idx_ok;
  assign wmask      = {{8{bus.be[3]}}, {8{bus.be[2]}}, {8{bus.be[1]}}, {8{bus.be[0]}}};
  assign unused_bus = ^{bus.addr[31:8], bus.addr[1:0], bus.wdata};

`ifdef EDGE_IRQ_DEBOUNCE_EN
  localparam int unsigned DbW = $clog2(DebounceCycles + 1);
  localparam logic [DbW-1:0] DbLast = DbW'(DebounceCycles - 1);

  logic [NumChannels-1:0][DbW-1:0] db_cnt_q, db_cnt_d;
  logic [NumChannels-1:0]          filt_q, filt_d;

  // A channel flips only after DebounceCycles consecutive disagreeing samples.
  always_comb begin
    db_cnt_d = db_cnt_q;
    filt_d   = filt_q;
    for (int i = 0; i < NumChannels; i++) begin
      if (gpio_i[i] != filt_q[i]) begin
        if (db_cnt_q[i] == DbLast) begin
          filt_d[i]   = gpio_i[i];
          db_cnt_d[i] = '0;
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DbW'(1);
        end
      end else begin
        db_cnt_d[i] = '0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      db_cnt_q <= '0;
      filt_q   <= '0;
    end else begin
      db_cnt_q <= db_cnt_d;
      filt_q   <= filt_d;
    end
  end

  assign filt = filt_q;
`else
  assign filt = gpio_i;
`endif

  always_comb begin
    edge_det = '0;
    for (int i = 0; i < NumChannels; i++) begin
      unique case (mode_q[2*i +: 2])
        2'd1:    edge_det[i] = filt[i] & ~prev_q[i];
        2'd2:    edge_det[i] = ~filt[i] & prev_q[i];
        2'd3:    edge_det[i] = filt[i] ^ prev_q[i];
        default: edge_det[i] = 1'b0;
      endcase
    end
    edge_det = edge_det & {NumChannels{en_q}};
  end

  always_comb begin
    en_d     = en_q;
    mode_d   = mode_q;
    irq_en_d = irq_en_q;
    w1c      = '0;
    cnt_clr  = 1'b0;
    prev_d   = filt;
    if (wr_ok) begin
      case (idx)
        6'd0: if (bus.be[0]) en_d = bus.wdata[0];
        6'd1: mode_d = (mode_q & ~wmask[MW-1:0]) | (bus.wdata[MW-1:0] & wmask[MW-1:0]);
        6'd2: irq_en_d = (irq_en_q & ~wmask[NumChannels-1:0])
                       | (bus.wdata[NumChannels-1:0] & wmask[NumChannels-1:0]);
        6'd3: w1c = bus.wdata[NumChannels-1:0] & wmask[NumChannels-1:0];
        6'd5: cnt_clr = |bus.be;
        default: ;
      endcase
    end

    // A hardware set in the same cycle as a W1C leaves the flag set.
    pending_d = (pending_q & ~w1c) | edge_det;

    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = CntWidth'(|edge_det);
    end else if ((|edge_det) && (cnt_q != {CntWidth{1'b1}})) begin
      cnt_d = cnt_q + CntWidth'(1);
    end

    case (idx)
      6'd0:    rd_val = {31'b0, en_q};
      6'd1:    rd_val = 32'(mode_q);
      6'd2:    rd_val = 32'(irq_en_q);
      6'd3:    rd_val = 32'(pending_q);
      6'd4:    rd_val = 32'(filt);
      6'd5:    rd_val = 32'(cnt_q);
      default: rd_val = '0;
    endcase

    rvalid_d = bus.req;
    rid_d    = bus.req ? bus.aid : 1'b0;
    err_d    = bus.req & ~idx_ok;
    rdata_d  = (bus.req & ~bus.we & idx_ok) ? rd_val : 32'h0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      en_q      <= 1'b0;
      mode_q    <= '0;
      irq_en_q  <= '0;
      pending_q <= '0;
      prev_q    <= '0;
      cnt_q     <= '0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rid_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      en_q      <= en_d;
      mode_q    <= mode_d;
      irq_en_q  <= irq_en_d;
      pending_q <= pending_d;
      prev_q    <= prev_d;
      cnt_q     <= cnt_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rid_q     <= rid_d;
      err_q     <= err_d;
    end
  end

  assign bus.gnt    = bus.req;
  assign bus.rvalid = rvalid_q;
  assign bus.rdata  = rdata_q;
  assign bus.rid    = rid_q;
  assign bus.err    = err_q;
  assign irq_o      = |(pending_q & irq_en_q);
endmodule
